// File: rtl/operand_entry_ctrl_if.sv
// Front-panel and datapath signal bundle for operand_entry_ctrl.
// master: the controller; slave: the panel/datapath side.
interface operand_entry_ctrl_if;
  logic [3:0] BTN;
  logic [3:0] LEDS;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       start;
  logic       done;
  logic [3:0] result;
  logic       err;

  modport master (
    input  BTN, done, result,
    output LEDS, op_a, op_b, start, err
  );

  modport slave (
    output BTN, done, result,
    input  LEDS, op_a, op_b, start, err
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Front-panel sequencer: debounced buttons drive operand entry, datapath start and result display.
// Optional macro ENTRY_BLINK_EN: blink LEDS while editing an operand.
module operand_entry_ctrl #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned BLINK_DIV      = 8
) (
  input logic                  clk,
  input logic                  reset,
  operand_entry_ctrl_if.master bus
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);

  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 2 || BLINK_DIV < 1) begin : g_bad_params
    $error("operand_entry_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER_A, S_ENTER_B, S_START, S_WAIT, S_SHOW
  } state_e;

  // ---------------- input path ----------------
  logic [3:0]     sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
  logic [DCW-1:0] deb_cnt_q [4];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= bus.BTN;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int unsigned i = 0; i < 4; i++) begin
        // Count consecutive samples disagreeing with the accepted level.
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic p_inc, p_dec, p_conf, p_abort;

  always_comb begin
    p_abort = press_q[3];
    p_conf  = press_q[2] & ~press_q[3];
    p_dec   = press_q[1] & ~(|press_q[3:2]);
    p_inc   = press_q[0] & ~(|press_q[3:1]);
  end

  // ---------------- sequencer ----------------
  state_e         state_q, state_d;
  logic [3:0]     value_q, value_d;
  logic [3:0]     op_a_q, op_a_d;
  logic [3:0]     op_b_q, op_b_d;
  logic [3:0]     res_q, res_d;
  logic [3:0]     leds_q, leds_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           edit;
  logic           blank;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    edit       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (p_conf) begin
          state_d = S_ENTER_A;
          value_d = '0;
        end
      end
      S_ENTER_A, S_ENTER_B: begin
        if (p_abort) begin
          state_d = S_IDLE;
        end else if (p_conf) begin
          if (state_q == S_ENTER_A) begin
            op_a_d  = value_q;
            value_d = '0;
            state_d = S_ENTER_B;
          end else begin
            op_b_d  = value_q;
            state_d = S_START;
          end
        end else if (p_inc) begin
          value_d = value_q + 4'd1;
          edit    = 1'b1;
        end else if (p_dec) begin
          value_d = value_q - 4'd1;
          edit    = 1'b1;
        end
      end
      S_START: begin
        err_d      = 1'b0;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Abort beats done; done beats a coincident timeout.
        if (p_abort) begin
          state_d = S_IDLE;
        end else if (bus.done) begin
          res_d   = bus.result;
          state_d = S_SHOW;
        end else if (wait_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          res_d   = 4'hF;
          state_d = S_SHOW;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (p_abort) begin
          state_d = S_IDLE;
        end else if (p_conf) begin
          state_d = S_ENTER_A;
          value_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);

    unique case (state_d)
      S_ENTER_A, S_ENTER_B: leds_d = blank ? 4'h0 : value_d;
      S_SHOW:               leds_d = res_d;
      default:              leds_d = 4'h0;
    endcase
  end

`ifdef ENTRY_BLINK_EN
  localparam int unsigned BCW = $clog2(BLINK_DIV + 1);

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_off_q, blink_off_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (state_d == S_ENTER_A || state_d == S_ENTER_B) begin
      if (state_d != state_q || edit) begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
      end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
      end
    end
    blank = blink_off_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      leds_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      leds_q     <= leds_d;
      err_q      <= err_d;
      start_q    <= start_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.LEDS  = leds_q;
  assign bus.op_a  = op_a_q;
  assign bus.op_b  = op_b_q;
  assign bus.start = start_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl: vector table for entry/editing, hand sequences for timing corners.
module tb_operand_entry_ctrl;

  logic clk = 1'b0;
  logic reset;

  operand_entry_ctrl_if bus ();

  operand_entry_ctrl #(
    .DEB_CYCLES    (4),
    .TIMEOUT_CYCLES(64),
    .BLINK_DIV     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_start = 0;

  logic       dp_en  = 1'b0;
  int         dp_dly = 5;
  logic [3:0] dp_res = 4'h9;

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  leds;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        err;
    int          starts;
  } vec_t;

  vec_t tbl [25];

  always @(negedge clk) if (bus.start === 1'b1) n_start++;

  // Datapath model: answer each start after dp_dly cycles with a one-cycle done.
  initial begin
    bus.done   = 1'b0;
    bus.result = 4'h0;
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1 && dp_en) begin
        repeat (dp_dly) @(negedge clk);
        bus.done   = 1'b1;
        bus.result = dp_res;
        @(negedge clk);
        bus.done   = 1'b0;
        bus.result = 4'h0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    bus.BTN = m;
    repeat (10) @(negedge clk);
    bus.BTN = 4'h0;
    repeat (12) @(negedge clk);
  endtask

  // Press confirm and return at the negedge where start is first seen high.
  task automatic confirm_catch(input string nm);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bus.BTN = 4'b0100;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.start === 1'b1) ok = 1'b1;
    end
    bus.BTN = 4'h0;
    chk({nm, "_start_seen"}, 32'(ok), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[1]  = '{4'b0101, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[2]  = '{4'b0001, 4'h1, 4'h0, 4'h0, 1'b0, 0};
    tbl[3]  = '{4'b0001, 4'h2, 4'h0, 4'h0, 1'b0, 0};
    tbl[4]  = '{4'b0010, 4'h1, 4'h0, 4'h0, 1'b0, 0};
    tbl[5]  = '{4'b0010, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[6]  = '{4'b0010, 4'hF, 4'h0, 4'h0, 1'b0, 0};
    tbl[7]  = '{4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[8]  = '{4'b0001, 4'h1, 4'h0, 4'h0, 1'b0, 0};
    tbl[9]  = '{4'b0011, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[10] = '{4'b0001, 4'h1, 4'h0, 4'h0, 1'b0, 0};
    tbl[11] = '{4'b0001, 4'h2, 4'h0, 4'h0, 1'b0, 0};
    tbl[12] = '{4'b0001, 4'h3, 4'h0, 4'h0, 1'b0, 0};
    tbl[13] = '{4'b0100, 4'h0, 4'h3, 4'h0, 1'b0, 0};
    tbl[14] = '{4'b0010, 4'hF, 4'h3, 4'h0, 1'b0, 0};
    tbl[15] = '{4'b0100, 4'h9, 4'h3, 4'hF, 1'b0, 1};
    tbl[16] = '{4'b0001, 4'h9, 4'h3, 4'hF, 1'b0, 1};
    tbl[17] = '{4'b1000, 4'h0, 4'h3, 4'hF, 1'b0, 1};
    tbl[18] = '{4'b0100, 4'h0, 4'h3, 4'hF, 1'b0, 1};
    tbl[19] = '{4'b0001, 4'h1, 4'h3, 4'hF, 1'b0, 1};
    tbl[20] = '{4'b0001, 4'h2, 4'h3, 4'hF, 1'b0, 1};
    tbl[21] = '{4'b0001, 4'h3, 4'h3, 4'hF, 1'b0, 1};
    tbl[22] = '{4'b0001, 4'h4, 4'h3, 4'hF, 1'b0, 1};
    tbl[23] = '{4'b0001, 4'h5, 4'h3, 4'hF, 1'b0, 1};
    tbl[24] = '{4'b1001, 4'h0, 4'h3, 4'hF, 1'b0, 1};

    bus.BTN = 4'h0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_leds",  32'(bus.LEDS),  32'h0);
    chk("rst_start", 32'(bus.start), 32'h0);
    chk("rst_err",   32'(bus.err),   32'h0);
    chk("rst_op_a",  32'(bus.op_a),  32'h0);
    chk("rst_op_b",  32'(bus.op_b),  32'h0);

    // Glitches of 2 and 3 cycles in ENTER_A must not edit the value.
    press(4'b0100);
    chk("enter_a_leds", 32'(bus.LEDS), 32'h0);
    for (int g = 2; g <= 3; g++) begin
      @(negedge clk);
      bus.BTN = 4'b0001;
      repeat (g) @(negedge clk);
      bus.BTN = 4'h0;
      repeat (15) @(negedge clk);
      chk($sformatf("glitch%0d_leds", g), 32'(bus.LEDS), 32'h0);
    end

    // Press lands on the 7th edge after first sample; LEDS follows one edge later.
    @(negedge clk);
    bus.BTN = 4'b0001;
    repeat (7) @(posedge clk);
    #1 chk("lat_before", 32'(bus.LEDS), 32'h0);
    @(posedge clk);
    #1 chk("lat_after", 32'(bus.LEDS), 32'h1);
    @(negedge clk);
    bus.BTN = 4'h0;
    repeat (12) @(negedge clk);
    press(4'b1000);
    chk("abort_leds", 32'(bus.LEDS), 32'h0);

    dp_en  = 1'b1;
    dp_dly = 5;
    dp_res = 4'h9;
    for (int r = 0; r < 25; r++) begin
      press(tbl[r].btn);
      chk($sformatf("row%0d_leds", r),   32'(bus.LEDS), 32'(tbl[r].leds));
      chk($sformatf("row%0d_op_a", r),   32'(bus.op_a), 32'(tbl[r].op_a));
      chk($sformatf("row%0d_op_b", r),   32'(bus.op_b), 32'(tbl[r].op_b));
      chk($sformatf("row%0d_err", r),    32'(bus.err),  32'(tbl[r].err));
      chk($sformatf("row%0d_starts", r), 32'(n_start),  32'(tbl[r].starts));
    end

    // Timeout: no done, SHOW with F and err on the 64th WAIT edge.
    dp_en = 1'b0;
    press(4'b0100);
    repeat (3) press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    confirm_catch("to");
    repeat (64) @(posedge clk);
    #1;
    chk("to_pre_leds", 32'(bus.LEDS), 32'h0);
    chk("to_pre_err",  32'(bus.err),  32'h0);
    @(posedge clk);
    #1;
    chk("to_leds", 32'(bus.LEDS), 32'hF);
    chk("to_err",  32'(bus.err),  32'h1);
    chk("to_op_a", 32'(bus.op_a), 32'h3);
    chk("to_op_b", 32'(bus.op_b), 32'hF);
    repeat (5) @(negedge clk);
    chk("to_starts", 32'(n_start), 32'd2);
    press(4'b0100);
    chk("to_reenter_leds", 32'(bus.LEDS), 32'h0);
    chk("to_reenter_err",  32'(bus.err),  32'h1);

    // done on the timeout edge wins.
    dp_en  = 1'b1;
    dp_dly = 64;
    dp_res = 4'h6;
    press(4'b0100);
    press(4'b0010);
    confirm_catch("tie");
    repeat (64) @(posedge clk);
    #1;
    chk("tie_pre_leds", 32'(bus.LEDS), 32'h0);
    chk("tie_pre_err",  32'(bus.err),  32'h0);
    @(posedge clk);
    #1;
    chk("tie_leds", 32'(bus.LEDS), 32'h6);
    chk("tie_err",  32'(bus.err),  32'h0);
    chk("tie_op_a", 32'(bus.op_a), 32'h0);
    chk("tie_op_b", 32'(bus.op_b), 32'hF);

    // Reset during WAIT; the later done must be dropped.
    dp_dly = 5;
    dp_res = 4'h9;
    repeat (5) @(negedge clk);
    press(4'b0100);
    press(4'b0001);
    press(4'b0100);
    confirm_catch("rw");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("rw_leds",  32'(bus.LEDS),  32'h0);
    chk("rw_err",   32'(bus.err),   32'h0);
    chk("rw_start", 32'(bus.start), 32'h0);
    chk("rw_op_a",  32'(bus.op_a),  32'h0);
    chk("rw_op_b",  32'(bus.op_b),  32'h0);
    press(4'b0001);
    chk("rw_idle_leds", 32'(bus.LEDS), 32'h0);
    press(4'b0100);
    press(4'b0001);
    chk("rw_alive_leds", 32'(bus.LEDS), 32'h1);
    chk("rw_starts", 32'(n_start), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
